// File: rtl/inst_rom_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// inst_rom_arbiter_pkg
//   Shared types and helpers for the instruction-ROM arbiter.
//   - gnt_sel_e : which requester (if any) owns the ROM port this cycle
//   - sat_inc8  : saturating increment for the 8-bit rejected-request counter
// -----------------------------------------------------------------------------
package inst_rom_arbiter_pkg;

    localparam int unsigned ERR_CNT_W = 8;

    typedef enum logic [1:0] {
        SEL_NONE = 2'd0,
        SEL_IF   = 2'd1,
        SEL_DBG  = 2'd2
    } gnt_sel_e;

    function automatic logic [ERR_CNT_W-1:0] sat_inc8(input logic [ERR_CNT_W-1:0] v);
        return (v == '1) ? v : v + ERR_CNT_W'(1);
    endfunction

endpackage

// File: rtl/inst_addr_check.sv
// -----------------------------------------------------------------------------
// inst_addr_check
//   Pure-combinational legality check of an instruction byte address.
//   Ports:
//     addr_i : byte address to check
//     err_o  : 1 if misaligned (addr[1:0] != 0) or beyond the ROM
//              (any bit at or above MEM_LOG2+2 set)
// -----------------------------------------------------------------------------
module inst_addr_check #(
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned MEM_LOG2 = 17
) (
    input  logic [ADDR_W-1:0] addr_i,
    output logic              err_o
);

    logic misaligned;
    logic out_of_range;

    assign misaligned   = (addr_i[1:0] != 2'b00);
    // A shift keeps this legal even if the ROM spans the full address space.
    assign out_of_range = ((addr_i >> (MEM_LOG2 + 2)) != '0);
    assign err_o        = misaligned | out_of_range;

endmodule

// File: rtl/inst_rom_arbiter.sv
// -----------------------------------------------------------------------------
// inst_rom_arbiter
//   Shares the single-read-port instruction ROM between the fetch port (F)
//   and the debug/loader port (D). Fetch has priority; D is granted after
//   being denied MAX_WAIT consecutive cycles. Illegal addresses are answered
//   with an error response and never reach the ROM.
//   Ports:
//     clk, rst                   : clock, async active-low reset
//     if_req/if_addr             : fetch request and byte address
//     if_gnt/if_stall            : fetch accepted / fetch held off (comb.)
//     if_rvalid/if_rdata/if_err  : registered fetch response
//     dbg_req/dbg_addr           : debug read request and byte address
//     dbg_gnt                    : debug accepted (comb.)
//     dbg_rvalid/rdata/err       : registered debug response
//     rom_ce/rom_addr/rom_data   : ROM port (data returns same cycle)
//     err_cnt                    : saturating count of rejected requests
// -----------------------------------------------------------------------------
module inst_rom_arbiter
    import inst_rom_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned MEM_LOG2 = 17,
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 if_req,
    input  logic [ADDR_W-1:0]    if_addr,
    output logic                 if_gnt,
    output logic                 if_stall,
    output logic                 if_rvalid,
    output logic [DATA_W-1:0]    if_rdata,
    output logic                 if_err,
    input  logic                 dbg_req,
    input  logic [ADDR_W-1:0]    dbg_addr,
    output logic                 dbg_gnt,
    output logic                 dbg_rvalid,
    output logic [DATA_W-1:0]    dbg_rdata,
    output logic                 dbg_err,
    output logic                 rom_ce,
    output logic [ADDR_W-1:0]    rom_addr,
    input  logic [DATA_W-1:0]    rom_data,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    localparam int unsigned WAIT_W = $clog2(MAX_WAIT + 1);

    gnt_sel_e            sel;
    logic [ADDR_W-1:0]   gnt_addr;
    logic                gnt_any;
    logic                gnt_err;
    logic [DATA_W-1:0]   rsp_data;

    logic [WAIT_W-1:0]   wait_q, wait_d;
    logic                wait_full;

    logic                if_rvalid_q, dbg_rvalid_q;
    logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0]   dbg_rdata_q, dbg_rdata_d;
    logic                if_err_q, if_err_d;
    logic                dbg_err_q, dbg_err_d;
    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

    assign wait_full = (wait_q == WAIT_W'(MAX_WAIT));

    // Grant selection: D wins only when F is idle or D has hit its wait bound.
    always_comb begin
        sel = SEL_NONE;
        if (dbg_req && (!if_req || wait_full)) begin
            sel = SEL_DBG;
        end else if (if_req) begin
            sel = SEL_IF;
        end
    end

    assign dbg_gnt  = (sel == SEL_DBG);
    assign if_gnt   = (sel == SEL_IF);
    assign if_stall = if_req & ~if_gnt;
    assign gnt_any  = (sel != SEL_NONE);

    always_comb begin
        gnt_addr = '0;
        case (sel)
            SEL_IF:  gnt_addr = if_addr;
            SEL_DBG: gnt_addr = dbg_addr;
            default: gnt_addr = '0;
        endcase
    end

    inst_addr_check #(
        .ADDR_W   (ADDR_W),
        .MEM_LOG2 (MEM_LOG2)
    ) u_addr_check (
        .addr_i (gnt_addr),
        .err_o  (gnt_err)
    );

    assign rom_ce   = gnt_any & ~gnt_err;
    assign rom_addr = gnt_addr;
    assign rsp_data = gnt_err ? '0 : rom_data;

    // Next-state logic for counters and response holding registers.
    always_comb begin
        wait_d = '0;
        if (dbg_req && !dbg_gnt) begin
            wait_d = wait_full ? wait_q : wait_q + WAIT_W'(1);
        end

        if_rdata_d  = if_rdata_q;
        if_err_d    = if_err_q;
        dbg_rdata_d = dbg_rdata_q;
        dbg_err_d   = dbg_err_q;
        if (if_gnt) begin
            if_rdata_d = rsp_data;
            if_err_d   = gnt_err;
        end
        if (dbg_gnt) begin
            dbg_rdata_d = rsp_data;
            dbg_err_d   = gnt_err;
        end

        err_cnt_d = err_cnt_q;
        if (gnt_any && gnt_err) begin
            err_cnt_d = sat_inc8(err_cnt_q);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_q       <= '0;
            if_rvalid_q  <= 1'b0;
            if_rdata_q   <= '0;
            if_err_q     <= 1'b0;
            dbg_rvalid_q <= 1'b0;
            dbg_rdata_q  <= '0;
            dbg_err_q    <= 1'b0;
            err_cnt_q    <= '0;
        end else begin
            wait_q       <= wait_d;
            if_rvalid_q  <= if_gnt;
            if_rdata_q   <= if_rdata_d;
            if_err_q     <= if_err_d;
            dbg_rvalid_q <= dbg_gnt;
            dbg_rdata_q  <= dbg_rdata_d;
            dbg_err_q    <= dbg_err_d;
            err_cnt_q    <= err_cnt_d;
        end
    end

    assign if_rvalid  = if_rvalid_q;
    assign if_rdata   = if_rdata_q;
    assign if_err     = if_err_q;
    assign dbg_rvalid = dbg_rvalid_q;
    assign dbg_rdata  = dbg_rdata_q;
    assign dbg_err    = dbg_err_q;
    assign err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_inst_rom_arbiter.sv
// -----------------------------------------------------------------------------
// tb_inst_rom_arbiter
//   Directed bench for inst_rom_arbiter. The ROM model returns the word index
//   (addr >> 2) when enabled and a poison pattern otherwise, so an error
//   response that leaks ROM data is visible.
// -----------------------------------------------------------------------------
module tb_inst_rom_arbiter;

    logic        clk;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt, if_stall, if_rvalid, if_err;
    logic [31:0] if_rdata;
    logic        dbg_req;
    logic [31:0] dbg_addr;
    logic        dbg_gnt, dbg_rvalid, dbg_err;
    logic [31:0] dbg_rdata;
    logic        rom_ce;
    logic [31:0] rom_addr;
    logic [31:0] rom_data;
    logic [7:0]  err_cnt;

    int n_tests;
    int n_fail;

    inst_rom_arbiter #(
        .ADDR_W   (32),
        .DATA_W   (32),
        .MEM_LOG2 (17),
        .MAX_WAIT (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .if_req     (if_req),
        .if_addr    (if_addr),
        .if_gnt     (if_gnt),
        .if_stall   (if_stall),
        .if_rvalid  (if_rvalid),
        .if_rdata   (if_rdata),
        .if_err     (if_err),
        .dbg_req    (dbg_req),
        .dbg_addr   (dbg_addr),
        .dbg_gnt    (dbg_gnt),
        .dbg_rvalid (dbg_rvalid),
        .dbg_rdata  (dbg_rdata),
        .dbg_err    (dbg_err),
        .rom_ce     (rom_ce),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .err_cnt    (err_cnt)
    );

    assign rom_data = rom_ce ? (rom_addr >> 2) : 32'hDEAD_BEEF;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_tests  = 0;
        n_fail   = 0;
        rst      = 1'b0;
        if_req   = 1'b0;
        if_addr  = '0;
        dbg_req  = 1'b0;
        dbg_addr = '0;

        // Reset state
        tick();
        chk("rst_if_rvalid", 32'(if_rvalid), 32'd0);
        chk("rst_if_rdata", if_rdata, 32'd0);
        chk("rst_dbg_rvalid", 32'(dbg_rvalid), 32'd0);
        chk("rst_err_cnt", 32'(err_cnt), 32'd0);
        chk("rst_rom_ce", 32'(rom_ce), 32'd0);
        chk("rst_rom_addr", rom_addr, 32'd0);
        tick();
        rst = 1'b1;

        // F only: three back-to-back fetches
        if_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if_addr = 32'(i * 4);
            #1;
            chk("f_gnt", 32'(if_gnt), 32'd1);
            chk("f_stall", 32'(if_stall), 32'd0);
            chk("f_rom_ce", 32'(rom_ce), 32'd1);
            chk("f_rom_addr", rom_addr, 32'(i * 4));
            tick();
            chk("f_rvalid", 32'(if_rvalid), 32'd1);
            chk("f_rdata", if_rdata, 32'(i));
            chk("f_err", 32'(if_err), 32'd0);
            chk("f_dbg_rvalid", 32'(dbg_rvalid), 32'd0);
        end
        if_req = 1'b0;
        #1;
        chk("idle_rom_ce", 32'(rom_ce), 32'd0);
        chk("idle_rom_addr", rom_addr, 32'd0);
        tick();
        chk("f_rvalid_pulse", 32'(if_rvalid), 32'd0);
        chk("f_rdata_hold", if_rdata, 32'd2);

        // Starvation: D granted after MAX_WAIT denied cycles
        if_req   = 1'b1;
        if_addr  = 32'h40;
        dbg_req  = 1'b1;
        dbg_addr = 32'h10;
        for (int c = 0; c <= 4; c++) begin
            #1;
            chk("st_dbg_gnt", 32'(dbg_gnt), (c == 4) ? 32'd1 : 32'd0);
            chk("st_if_gnt", 32'(if_gnt), (c == 4) ? 32'd0 : 32'd1);
            chk("st_if_stall", 32'(if_stall), (c == 4) ? 32'd1 : 32'd0);
            tick();
        end
        chk("st_dbg_rvalid", 32'(dbg_rvalid), 32'd1);
        chk("st_dbg_rdata", dbg_rdata, 32'd4);
        chk("st_if_rvalid", 32'(if_rvalid), 32'd0);
        dbg_req = 1'b0;
        if_req  = 1'b0;
        tick();
        chk("st_dbg_pulse", 32'(dbg_rvalid), 32'd0);

        // Idle F: D granted immediately
        dbg_req  = 1'b1;
        dbg_addr = 32'h20;
        #1;
        chk("idf_dbg_gnt", 32'(dbg_gnt), 32'd1);
        chk("idf_if_stall", 32'(if_stall), 32'd0);
        tick();
        chk("idf_dbg_rvalid", 32'(dbg_rvalid), 32'd1);
        chk("idf_dbg_rdata", dbg_rdata, 32'd8);

        // Wait counter starts from 0 after the idle grant, and clears on drop
        if_req   = 1'b1;
        if_addr  = 32'h0;
        dbg_addr = 32'h24;
        tick();
        tick();             // D denied twice
        dbg_req = 1'b0;     // drop clears the count
        tick();
        dbg_req = 1'b1;
        for (int c = 0; c <= 4; c++) begin
            #1;
            chk("drop_dbg_gnt", 32'(dbg_gnt), (c == 4) ? 32'd1 : 32'd0);
            tick();
        end
        chk("drop_dbg_rdata", dbg_rdata, 32'd9);
        dbg_req = 1'b0;
        if_req  = 1'b0;
        tick();

        // Errors: misaligned fetch, then out-of-range debug read
        if_req  = 1'b1;
        if_addr = 32'h2;
        #1;
        chk("ef_gnt", 32'(if_gnt), 32'd1);
        chk("ef_rom_ce", 32'(rom_ce), 32'd0);
        tick();
        if_req = 1'b0;
        chk("ef_rvalid", 32'(if_rvalid), 32'd1);
        chk("ef_err", 32'(if_err), 32'd1);
        chk("ef_rdata", if_rdata, 32'd0);
        chk("ef_err_cnt", 32'(err_cnt), 32'd1);
        dbg_req  = 1'b1;
        dbg_addr = 32'h0008_0000;
        #1;
        chk("ed_gnt", 32'(dbg_gnt), 32'd1);
        chk("ed_rom_ce", 32'(rom_ce), 32'd0);
        tick();
        chk("ed_err", 32'(dbg_err), 32'd1);
        chk("ed_rdata", dbg_rdata, 32'd0);
        chk("ed_err_cnt", 32'(err_cnt), 32'd2);
        dbg_addr = 32'h0007_FFFC;   // last legal word
        tick();
        chk("ed_last_err", 32'(dbg_err), 32'd0);
        chk("ed_last_rdata", dbg_rdata, 32'h0001_FFFF);
        chk("ed_last_cnt", 32'(err_cnt), 32'd2);
        dbg_req = 1'b0;

        // Saturation: 300 misaligned fetches
        if_req  = 1'b1;
        if_addr = 32'h1;
        for (int k = 1; k <= 300; k++) begin
            tick();
            if (k == 252) chk("sat_254", 32'(err_cnt), 32'd254);
            if (k == 253) chk("sat_255", 32'(err_cnt), 32'd255);
        end
        chk("sat_hold", 32'(err_cnt), 32'd255);

        // Reset mid-operation
        if_addr = 32'h4;
        tick();
        if_req = 1'b0;
        chk("rm_rvalid_pre", 32'(if_rvalid), 32'd1);
        chk("rm_rdata_pre", if_rdata, 32'd1);
        rst = 1'b0;
        #1;
        chk("rm_rvalid", 32'(if_rvalid), 32'd0);
        chk("rm_rdata", if_rdata, 32'd0);
        chk("rm_err_cnt", 32'(err_cnt), 32'd0);
        chk("rm_dbg_rdata", dbg_rdata, 32'd0);
        tick();
        rst     = 1'b1;
        if_req  = 1'b1;
        if_addr = 32'hC;
        #1;
        chk("rm_post_gnt", 32'(if_gnt), 32'd1);
        tick();
        if_req = 1'b0;
        chk("rm_post_rvalid", 32'(if_rvalid), 32'd1);
        chk("rm_post_rdata", if_rdata, 32'd3);
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/inst_rom_arbiter.md
# inst_rom_arbiter

Shares the single-read-port instruction ROM between two requesters: the IF-stage fetch (port F) and the debug/loader read port (port D). Each cycle it grants at most one requester and drives the ROM chip-enable and address. It registers the returned word into a per-port response. Fetch has priority, and a starvation counter bounds how long port D can wait. Illegal addresses are rejected without touching the ROM.

## Interface
Parameters:
- `ADDR_W`, 32, byte-address width
- `DATA_W`, 32, instruction word width
- `MEM_LOG2`, 17, log2 of ROM depth in words (ROM index = addr[MEM_LOG2+1:2])
- `MAX_WAIT`, 4, maximum cycles port D is denied while requesting (≥1)

Ports:
- `clk`  in  1  clock, all state on rising edge
- `rst`  in  1  asynchronous, active-low reset
- `if_req`  in  1  fetch request (pipeline ce)
- `if_addr`  in  ADDR_W  fetch byte address
- `if_gnt`  out  1  fetch accepted this cycle
- `if_stall`  out  1  = if_req & ~if_gnt
- `if_rvalid`  out  1  fetch response valid
- `if_rdata`  out  DATA_W  fetched instruction
- `if_err`  out  1  fetch response is an error
- `dbg_req`  in  1  debug read request
- `dbg_addr`  in  ADDR_W  debug byte address
- `dbg_gnt`  out  1  debug accepted this cycle
- `dbg_rvalid`  out  1  debug response valid
- `dbg_rdata`  out  DATA_W  debug read data
- `dbg_err`  out  1  debug response is an error
- `rom_ce`  out  1  ROM chip enable
- `rom_addr`  out  ADDR_W  ROM byte address
- `rom_data`  in  DATA_W  ROM word (combinational, same cycle)
- `err_cnt`  out  8  saturating count of rejected requests

## Operation
- **Grant (combinational):**
  - `dbg_gnt = dbg_req & (~if_req | wait_cnt == MAX_WAIT)`.
  - `if_gnt = if_req & ~dbg_gnt`.
  - At most one grant per cycle.
- **wait_cnt** (width clog2(MAX_WAIT+1)):
  - Increments when dbg_req & ~dbg_gnt, saturating at MAX_WAIT.
  - Clears when dbg_gnt or ~dbg_req.
- **Address check (granted request):**
  - Error if addr[1:0] ≠ 0 or addr[ADDR_W-1:MEM_LOG2+2] ≠ 0.
  - An error grant never asserts rom_ce.
- **ROM drive:**
  - rom_ce = 1 only for a legal granted request. rom_addr = the granted address.
  - When idle, rom_ce = 0 and rom_addr = 0.
- **Response:** On the edge after a grant, the granted port's rvalid = 1, rdata = rom_data, err = 0.
  - For an error grant: rdata = 0, err = 1.
  - rvalid is a single-cycle pulse, so back-to-back grants give back-to-back pulses.
  - rdata/err hold their last value while rvalid = 0.
  - The non-granted port's rvalid = 0.
- **err_cnt:** Increments once per error grant and saturates at 255. Cleared only by reset.
- **Handshake:** A requester holds req and addr stable until its gnt. Dropping req before gnt is legal and clears wait_cnt.

## Timing
- Latency is grant cycle N → rvalid at N+1. Throughput is one access per cycle total.
- Worst-case port D wait is MAX_WAIT cycles. Port F is stalled for exactly one cycle per D grant while if_req is held.
- Reset value is 0 for all of the following:
  - the rvalid, rdata and err outputs of both ports
  - err_cnt and wait_cnt
- Grants, rom_ce and if_stall are combinational and are 0 whenever their requests are 0.
- Assertion of rst mid-operation drops pending responses immediately; no response is produced for a grant made in the cycle reset asserts.
- After deassertion, the first grant is possible in the first clock cycle.

## Structure
- Shared defines: ZeroWord, ChipEnable/ChipDisable, InstAddrBus/InstBus widths, and MEM_LOG2 default (InstMemNumLog2). These live with the existing global defines, not in this block.
- Sub-module `inst_addr_check` is a pure-combinational alignment/range check. The block instantiates it once, on the muxed granted address.
- Everything else lives in the top module: grant logic, wait counter, response registers, and err_cnt.

## Test plan
- **F only:** if_req=1, if_addr=0x0,0x4,0x8 on consecutive cycles → if_gnt=1 each cycle; if_rvalid=1 one cycle later with ROM words 0,1,2; dbg outputs stay 0.
- **Starvation:** MAX_WAIT=4, if_req=1 held, dbg_req asserted at cycle 0 with addr 0x10 → dbg_gnt at cycle 4, if_stall=1 at cycle 4 only; dbg_rvalid at cycle 5 with word 4.
- **Idle F:** if_req=0, dbg_req=1 addr 0x20 → dbg_gnt same cycle; dbg_rvalid next cycle with word 8; wait_cnt stays 0.
- **Errors:** if_addr=0x2 → rom_ce=0, if_rvalid=1, if_err=1, if_rdata=0, err_cnt=1. Then dbg_addr=1<<(MEM_LOG2+2) → dbg_err=1, err_cnt=2.
- **Saturation:** 300 consecutive misaligned fetches → err_cnt=255 and holds at 255.
- **Reset mid-op:** assert rst low in the cycle after a grant, while rvalid=1 → all outputs 0 at once. Release, then if_req=1 addr 0 → normal response one cycle after the grant.
